// File: rtl/stream_demux_pkg.sv
// stream_demux shared definitions.
// Select-width helper and channel state encoding.
package stream_demux_pkg;

   typedef enum logic {
      CH_EMPTY = 1'b0,
      CH_FULL  = 1'b1
   } ch_state_e;

   // Bits needed to index n channels (n >= 2).
   function automatic int sel_w(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/demux_ch_reg.sv
// One-entry channel register of stream_demux.
// Load has priority over drain so fill+drain stays full.
module demux_ch_reg
   import stream_demux_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              drain_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   ch_state_e         state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;

   // Next state: capture on load, empty on drain-only.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      if (load_i) begin
         state_d = CH_FULL;
         data_d  = data_i;
      end else if (drain_i) begin
         state_d = CH_EMPTY;
      end
   end

   // State and payload registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CH_EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = (state_q == CH_FULL);
   assign data_o  = data_q;

endmodule

// File: rtl/stream_demux.sv
// Stream demultiplexer: one input, NUM_CH one-entry
// output channels, addressed or round-robin routing.
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int NUM_CH  = 4,
   parameter int RR_MODE = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [sel_w(NUM_CH)-1:0] in_sel,
   output logic [NUM_CH-1:0]        out_valid,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic                     drop_free
);

   localparam int SEL_W = sel_w(NUM_CH);

   logic [SEL_W-1:0]  rr_q, rr_d;
   logic [SEL_W-1:0]  tgt;
   logic              rst_done_q;
   logic              drop_free_q;
   logic              accept;
   logic [NUM_CH-1:0] load_v;
   logic [NUM_CH-1:0] drain_v;
   logic [NUM_CH-1:0] full_d;

   assign tgt = (RR_MODE != 0) ? rr_q : in_sel;

   // rst_done_q blocks acceptance in the release cycle.
   assign in_ready = rst_done_q &
                     (~out_valid[tgt] | out_ready[tgt]);
   assign accept   = in_valid & in_ready;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign load_v[k]  = accept & (tgt == SEL_W'(k));
      assign drain_v[k] = out_valid[k] & out_ready[k];
      assign full_d[k]  = load_v[k] |
                          (out_valid[k] & ~drain_v[k]);

      demux_ch_reg #(
         .DATA_W (DATA_W)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .load_i  (load_v[k]),
         .drain_i (drain_v[k]),
         .data_i  (in_data),
         .valid_o (out_valid[k]),
         .data_o  (out_data[k*DATA_W +: DATA_W])
      );
   end

   // Pointer moves only on an accepted beat.
   always_comb begin
      rr_d = rr_q;
      if (accept) rr_d = rr_q + SEL_W'(1);
   end

   // Pointer, reset-release and idle flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q        <= '0;
         rst_done_q  <= 1'b0;
         drop_free_q <= 1'b1;
      end else begin
         rr_q        <= rr_d;
         rst_done_q  <= 1'b1;
         drop_free_q <= ~|full_d;
      end
   end

   assign drop_free = drop_free_q;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: addressed and round-robin
// instances, per-channel scoreboard queues.
module tb_stream_demux;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   logic       a_in_valid = 0, a_in_ready;
   logic [7:0] a_in_data = 0;
   logic [1:0] a_in_sel = 0;
   logic [3:0] a_out_valid, a_out_ready = 0;
   logic [31:0] a_out_data;
   logic       a_drop_free;

   logic       r_in_valid = 0, r_in_ready;
   logic [7:0] r_in_data = 0;
   logic [1:0] r_in_sel = 0;
   logic [3:0] r_out_valid, r_out_ready = 0;
   logic [31:0] r_out_data;
   logic       r_drop_free;

   int total = 0;
   int bad = 0;

   logic [7:0] qa [4][$];
   logic [7:0] qr [4][$];
   logic [1:0] rr_m = 0;
   logic [7:0] mon_b;
   logic [3:0] exp_v;
   logic [7:0] pat [4];

   always #5 clk = ~clk;

   stream_demux #(
      .DATA_W (8), .NUM_CH (4), .RR_MODE (0)
   ) u_addr (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_data   (a_in_data),
      .in_sel    (a_in_sel),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_data  (a_out_data),
      .drop_free (a_drop_free)
   );

   stream_demux #(
      .DATA_W (8), .NUM_CH (4), .RR_MODE (1)
   ) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (r_in_valid),
      .in_ready  (r_in_ready),
      .in_data   (r_in_data),
      .in_sel    (r_in_sel),
      .out_valid (r_out_valid),
      .out_ready (r_out_ready),
      .out_data  (r_out_data),
      .drop_free (r_drop_free)
   );

   // Scoreboard: pop on output handshakes, push on input ones.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            qa[k].delete();
            qr[k].delete();
         end
         rr_m = 0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (a_out_valid[k] && a_out_ready[k]) begin
               total++;
               if (qa[k].size() == 0) begin
                  bad++;
                  $display("FAIL a_sb_ch%0d: got %h want none",
                           k, a_out_data[k*8 +: 8]);
               end else begin
                  mon_b = qa[k].pop_front();
                  if (a_out_data[k*8 +: 8] !== mon_b) begin
                     bad++;
                     $display("FAIL a_sb_ch%0d: got %h want %h",
                              k, a_out_data[k*8 +: 8], mon_b);
                  end
               end
            end
            if (r_out_valid[k] && r_out_ready[k]) begin
               total++;
               if (qr[k].size() == 0) begin
                  bad++;
                  $display("FAIL r_sb_ch%0d: got %h want none",
                           k, r_out_data[k*8 +: 8]);
               end else begin
                  mon_b = qr[k].pop_front();
                  if (r_out_data[k*8 +: 8] !== mon_b) begin
                     bad++;
                     $display("FAIL r_sb_ch%0d: got %h want %h",
                              k, r_out_data[k*8 +: 8], mon_b);
                  end
               end
            end
         end
         if (a_in_valid && a_in_ready)
            qa[a_in_sel].push_back(a_in_data);
         if (r_in_valid && r_in_ready) begin
            qr[rr_m].push_back(r_in_data);
            rr_m = rr_m + 2'd1;
         end
      end
   end

   task automatic test_reset();
      a_in_valid = 1; a_in_data = 8'h5A; a_in_sel = 2'd1;
      r_in_valid = 1; r_in_data = 8'h5B;
      a_out_ready = 4'hF; r_out_ready = 4'hF;
      #1 rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (a_in_ready !== 1'b0 || r_in_ready !== 1'b0) begin
         bad++;
         $display("FAIL rst_ready: got %b%b want 00",
                  a_in_ready, r_in_ready);
      end
      total++;
      if (a_out_valid !== 4'h0 || r_out_valid !== 4'h0) begin
         bad++;
         $display("FAIL rst_valid: got %h %h want 0 0",
                  a_out_valid, r_out_valid);
      end
      total++;
      if (a_out_data !== 32'h0 || r_out_data !== 32'h0) begin
         bad++;
         $display("FAIL rst_data: got %h %h want 0 0",
                  a_out_data, r_out_data);
      end
      total++;
      if (a_drop_free !== 1'b1 || r_drop_free !== 1'b1) begin
         bad++;
         $display("FAIL rst_free: got %b%b want 11",
                  a_drop_free, r_drop_free);
      end
      @(negedge clk); #1 rst_n = 1;
      #1;
      total++;
      if (a_in_ready !== 1'b0 || r_in_ready !== 1'b0) begin
         bad++;
         $display("FAIL rel_ready: got %b%b want 00",
                  a_in_ready, r_in_ready);
      end
      @(posedge clk); #1;
      a_in_valid = 0; r_in_valid = 0;
      @(posedge clk); #1;
      total++;
      if (a_out_valid !== 4'h0 || r_out_valid !== 4'h0) begin
         bad++;
         $display("FAIL rel_noacc: got %h %h want 0 0",
                  a_out_valid, r_out_valid);
      end
   endtask

   task automatic test_addr();
      pat[0] = 8'h3C; pat[1] = 8'h96;
      pat[2] = 8'hA5; pat[3] = 8'h0F;
      a_out_ready = 4'hF;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         a_in_valid = 1; a_in_sel = 2'(k); a_in_data = pat[k];
         #1;
         total++;
         if (a_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL addr_ready%0d: got %b want 1",
                     k, a_in_ready);
         end
         @(posedge clk); #1;
         a_in_valid = 0;
         exp_v = 4'b0001 << k;
         total++;
         if (a_out_valid !== exp_v ||
             a_out_data[k*8 +: 8] !== pat[k]) begin
            bad++;
            $display("FAIL addr_out%0d: got %b/%h want %b/%h", k,
                     a_out_valid, a_out_data[k*8 +: 8],
                     exp_v, pat[k]);
         end
         total++;
         if (a_drop_free !== 1'b0) begin
            bad++;
            $display("FAIL addr_busy%0d: got %b want 0",
                     k, a_drop_free);
         end
         @(posedge clk); #1;
         total++;
         if (a_out_valid !== 4'h0 || a_drop_free !== 1'b1) begin
            bad++;
            $display("FAIL addr_idle%0d: got %b/%b want 0000/1",
                     k, a_out_valid, a_drop_free);
         end
      end
   endtask

   task automatic test_stall();
      @(posedge clk); #1;
      a_out_ready = 4'b1101;
      a_in_valid = 1; a_in_sel = 2'd1; a_in_data = 8'h11;
      @(posedge clk); #1;
      a_in_data = 8'h22;
      #1;
      for (int c = 0; c < 2; c++) begin
         total++;
         if (a_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_ready%0d: got %b want 0",
                     c, a_in_ready);
         end
         total++;
         if (a_out_valid[1] !== 1'b1 ||
             a_out_data[15:8] !== 8'h11) begin
            bad++;
            $display("FAIL stall_hold%0d: got %b/%h want 1/11",
                     c, a_out_valid[1], a_out_data[15:8]);
         end
         @(posedge clk); #1;
      end
      a_out_ready[1] = 1'b1;
      #1;
      total++;
      if (a_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL stall_release: got %b want 1", a_in_ready);
      end
      @(posedge clk); #1;
      a_in_valid = 0;
      total++;
      if (a_out_valid !== 4'b0010 ||
          a_out_data[15:8] !== 8'h22) begin
         bad++;
         $display("FAIL stall_new: got %b/%h want 0010/22",
                  a_out_valid, a_out_data[15:8]);
      end
      a_out_ready = 4'hF;
   endtask

   task automatic test_indep();
      @(posedge clk); #1;
      a_out_ready = 4'b1110;
      a_in_valid = 1; a_in_sel = 2'd0; a_in_data = 8'h55;
      @(posedge clk); #1;
      a_out_ready = 4'hF;
      a_in_sel = 2'd1; a_in_data = 8'h66;
      @(posedge clk); #1;
      a_in_valid = 0;
      total++;
      if (a_out_valid !== 4'b0010 ||
          a_out_data[15:8] !== 8'h66) begin
         bad++;
         $display("FAIL indep: got %b/%h want 0010/66",
                  a_out_valid, a_out_data[15:8]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_rr();
      @(posedge clk); #1;
      r_out_ready = 4'hF; r_in_valid = 1;
      for (int i = 0; i < 6; i++) begin
         r_in_data = 8'(i + 1); r_in_sel = 2'(i * 3);
         #1;
         total++;
         if (r_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rr_ready%0d: got %b want 1",
                     i, r_in_ready);
         end
         @(posedge clk); #1;
         exp_v = 4'b0001 << (i % 4);
         total++;
         if (r_out_valid !== exp_v ||
             r_out_data[(i%4)*8 +: 8] !== 8'(i + 1)) begin
            bad++;
            $display("FAIL rr_beat%0d: got %b/%h want %b/%h", i,
                     r_out_valid, r_out_data[(i%4)*8 +: 8],
                     exp_v, 8'(i + 1));
         end
      end
      r_in_valid = 0;
      @(posedge clk); #1;
      total++;
      if (r_out_valid !== 4'h0) begin
         bad++;
         $display("FAIL rr_idle: got %b want 0000", r_out_valid);
      end
   endtask

   task automatic test_rr_stall();
      r_out_ready = 4'b1011; r_in_valid = 1;
      for (int i = 0; i < 4; i++) begin
         r_in_data = 8'(8'h07 + i);
         #1;
         total++;
         if (r_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rrs_fill%0d: got %b want 1",
                     i, r_in_ready);
         end
         @(posedge clk); #1;
      end
      r_in_data = 8'h0B;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++;
         if (r_in_ready !== 1'b0 || r_out_valid[2] !== 1'b1 ||
             r_out_data[23:16] !== 8'h07) begin
            bad++;
            $display("FAIL rrs_stall%0d: got %b/%b/%h want 0/1/07",
                     c, r_in_ready, r_out_valid[2],
                     r_out_data[23:16]);
         end
         @(posedge clk); #1;
      end
      r_out_ready[2] = 1'b1;
      #1;
      total++;
      if (r_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rrs_release: got %b want 1", r_in_ready);
      end
      @(posedge clk); #1;
      r_in_data = 8'h0C;
      total++;
      if (r_out_valid !== 4'b0100 ||
          r_out_data[23:16] !== 8'h0B) begin
         bad++;
         $display("FAIL rrs_ch2: got %b/%h want 0100/0b",
                  r_out_valid, r_out_data[23:16]);
      end
      @(posedge clk); #1;
      r_in_valid = 0;
      total++;
      if (r_out_valid !== 4'b1000 ||
          r_out_data[31:24] !== 8'h0C) begin
         bad++;
         $display("FAIL rrs_ch3: got %b/%h want 1000/0c",
                  r_out_valid, r_out_data[31:24]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      a_out_ready = 4'hF; a_in_sel = 2'd3; a_in_valid = 1;
      for (int i = 0; i < 8; i++) begin
         a_in_data = 8'(8'hC0 + i);
         #1;
         total++;
         if (a_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready%0d: got %b want 1",
                     i, a_in_ready);
         end
         @(posedge clk); #1;
         total++;
         if (a_out_valid !== 4'b1000 ||
             a_out_data[31:24] !== 8'(8'hC0 + i)) begin
            bad++;
            $display("FAIL b2b_out%0d: got %b/%h want 1000/%h", i,
                     a_out_valid, a_out_data[31:24],
                     8'(8'hC0 + i));
         end
      end
      a_in_valid = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      a_out_ready = 4'h0;
      a_in_valid = 1; a_in_sel = 2'd0; a_in_data = 8'h33;
      @(posedge clk); #1;
      a_in_sel = 2'd2; a_in_data = 8'h44;
      @(posedge clk); #1;
      a_in_valid = 0;
      total++;
      if (a_out_valid !== 4'b0101) begin
         bad++;
         $display("FAIL mid_full: got %b want 0101", a_out_valid);
      end
      #2 rst_n = 0;
      #1;
      total++;
      if (a_out_valid !== 4'h0 || a_out_data !== 32'h0) begin
         bad++;
         $display("FAIL mid_clear: got %b/%h want 0000/0",
                  a_out_valid, a_out_data);
      end
      total++;
      if (a_drop_free !== 1'b1 || a_in_ready !== 1'b0) begin
         bad++;
         $display("FAIL mid_flags: got %b/%b want 1/0",
                  a_drop_free, a_in_ready);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); #1 rst_n = 1;
      a_out_ready = 4'hF; r_out_ready = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (a_out_valid !== 4'h0 || r_out_valid !== 4'h0 ||
          a_drop_free !== 1'b1) begin
         bad++;
         $display("FAIL mid_stale: got %b %b/%b want 0 0/1",
                  a_out_valid, r_out_valid, a_drop_free);
      end
   endtask

   task automatic test_drain_all();
      for (int k = 0; k < 4; k++) begin
         total++;
         if (qa[k].size() != 0 || qr[k].size() != 0) begin
            bad++;
            $display("FAIL left_ch%0d: got %0d/%0d want 0/0", k,
                     qa[k].size(), qr[k].size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_addr();
      test_stall();
      test_indep();
      test_rr();
      test_rr_stall();
      test_back_to_back();
      test_reset_mid();
      @(negedge clk);
      test_drain_all();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
